ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage. Holds the architectural HI/LO registers.
- Consumes the operands and decoded md op of the instruction currently held in the ID/EX pipeline register, i.e. directly downstream of that register.
- Runs MULT/MULTU/DIV/DIVU over 32 iterations and raises a stall request to the control unit while a dependent instruction must wait.
- Executes MTHI/MTLO in one cycle and supplies HI/LO for MFHI/MFLO.

Parameters:
- XLEN, 32, operand/HI/LO width.
- ITER, 32, iteration count (must equal XLEN).

Ports:
- clk  in  1  clock; all state updates on the falling edge, matching the pipeline registers.
- reset  in  1  asynchronous, active-high reset.
- ex_nop  in  1  EX slot holds a bubble; no op may start.
- ex_md_op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHILO (read only).
- ex_op_A  in  32  rs operand, after forwarding.
- ex_op_B  in  32  rt operand, after forwarding.
- cu_stall  in  1  ID/EX register holds this edge (from any cause).
- md_abort  in  1  exception/eret in EX; cancel the op in flight.
- md_busy  out  1  iteration in progress.
- md_stall  out  1  stall request to the control unit.
- md_hi  out  32  HI register.
- md_lo  out  32  LO register.

Behaviour:
- Reset (async): HI=0, LO=0, busy=0, count=0, issued=0, internal accumulators=0. md_stall=0.
- "valid" = ex_md_op != NONE && !ex_nop.
- "start" = valid && !busy && !issued && !md_abort. Evaluated at each falling edge.
- issued flag:
  - Set on a start edge when cu_stall=1.
  - Cleared on any edge with cu_stall=0.
  - Purpose: the same held instruction never starts twice.
- md_stall (combinational) = busy && valid. MFHILO, MTHI/MTLO and a new mul/div all wait while busy.
- MTHI/MTLO on a start edge: HI (resp. LO) <= ex_op_A. busy stays 0.
- MFHILO: no state change. md_hi/md_lo already reflect completed results.
- Mul/div start edge:
  - Latch |A| and |B| for signed ops; raw A and B for unsigned ops.
  - Latch result sign and op kind.
  - Set count=ITER and busy=1.
- Each subsequent edge while busy does one iteration and decrements count:
  - Multiply: shift-add, 64-bit product accumulator.
  - Divide: restoring, one quotient bit per iteration.
- Edge where count goes 1->0:
  - Apply sign correction and write HI/LO. Multiply: HI = product[63:32], LO = product[31:0]. Divide: LO = quotient, HI = remainder.
  - busy=0 on the same edge.
  - Latency: the result is visible 32 falling edges after the start edge. md_stall drops in the cycle after the last edge.
- Signed result sign rules:
  - Product negated if A and B signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0 (two's-complement wrap).
- Divide by zero (B=0), signed or unsigned: LO=0xFFFFFFFF, HI=ex_op_A as latched. Still takes 32 iterations.
- md_abort:
  - While busy: busy=0 and count=0 on that edge; HI/LO unchanged.
  - On a would-be start edge: no start.
  - md_abort takes priority over a completion on the same edge, so HI/LO stay unchanged.
- Reset mid-operation: immediate return to the reset state; the partial result is discarded.
- cu_stall has no effect on iteration progress. The unit keeps running while the pipeline is frozen.

Decomposition:
- Shared package/header holds:
  - MD_NONE..MD_MFHILO op encodings (3-bit).
  - XLEN and the iteration count.
- Natural sub-module: md_iter_core, containing the 64-bit accumulator, divisor/multiplicand register, count and one-step datapath, with a start/abort/done interface.
- The top level holds HI/LO, the issued flag, sign handling and md_stall.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> md_busy=1 for 32 edges, then HI=0xFFFFFFFE, LO=0x00000001. md_stall=1 while an MFHILO sits in EX, and drops after.
- DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5 / 0 -> after 32 edges LO=0xFFFFFFFF, HI=5.
- MULT 3 x 4 held in EX with cu_stall=1 for 40 edges -> exactly one start. HI=0, LO=12; issued clears once cu_stall=0.
- MTHI 0x1234 then MTLO 0x5678 back-to-back -> HI=0x1234, LO=0x5678, md_busy never asserted. Then MULT issued with md_abort pulsed at iteration 10 -> busy=0 and HI/LO unchanged.
- Reset asserted mid-DIVU (iteration 15) -> HI=LO=0 and busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and sizing for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

  localparam int unsigned MD_XLEN = 32;
  localparam int unsigned MD_ITER = 32;

  typedef enum logic [2:0] {
    MD_NONE   = 3'd0,
    MD_MULT   = 3'd1,
    MD_MULTU  = 3'd2,
    MD_DIV    = 3'd3,
    MD_DIVU   = 3'd4,
    MD_MTHI   = 3'd5,
    MD_MTLO   = 3'd6,
    MD_MFHILO = 3'd7
  } md_op_e;

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iteration core: 2*XLEN accumulator, shift-add multiply / restoring divide,
// one step per falling edge. Operands arrive as unsigned magnitudes.
module md_iter_core #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              div_i,
  input  logic [XLEN-1:0]   opa_i,
  input  logic [XLEN-1:0]   opb_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2*XLEN-1:0] result_o
);

  localparam int unsigned CW = $clog2(ITER + 1);

  logic [2*XLEN-1:0] acc_q, acc_d, step;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [CW-1:0]     count_q, count_d;
  logic              busy_q, busy_d;
  logic [XLEN:0]     sum, trial;

  // Multiply keeps the multiplier in the low half and shifts right; divide
  // shifts the dividend left into the partial remainder (upper half).
  always_comb begin
    sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    if (div_i) begin
      if (!trial[XLEN]) step = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else              step = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      step = {sum, acc_q[XLEN-1:1]};
    end
  end

  always_comb begin
    acc_d   = acc_q;
    opb_d   = opb_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_o  = 1'b0;
    if (abort_i) begin
      busy_d  = 1'b0;
      count_d = '0;
    end else if (start_i) begin
      acc_d   = {{XLEN{1'b0}}, opa_i};
      opb_d   = opb_i;
      count_d = CW'(ITER);
      busy_d  = 1'b1;
    end else if (busy_q) begin
      acc_d   = step;
      count_d = count_q - CW'(1);
      if (count_q == CW'(1)) begin
        busy_d = 1'b0;
        done_o = 1'b1;
      end
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      opb_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o   = busy_q;
  assign result_o = step;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: HI/LO registers, issue tracking, sign
// handling and the stall request around the iterative core.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN,
  parameter int unsigned ITER = MD_ITER
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_nop,
  input  logic [2:0]      ex_md_op,
  input  logic [XLEN-1:0] ex_op_A,
  input  logic [XLEN-1:0] ex_op_B,
  input  logic            cu_stall,
  input  logic            md_abort,
  output logic            md_busy,
  output logic            md_stall,
  output logic [XLEN-1:0] md_hi,
  output logic [XLEN-1:0] md_lo
);

  md_op_e            op;
  logic              valid, start, md_start, signed_op, div_op, busy, done;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, mag_a, mag_b;
  logic              issued_q, issued_d, is_div_q, is_div_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic [2*XLEN-1:0] result, prod;
  logic [XLEN-1:0]   quo, rem;

  assign op        = md_op_e'(ex_md_op);
  assign valid     = (op != MD_NONE) && !ex_nop;
  assign start     = valid && !busy && !issued_q && !md_abort;
  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign div_op    = (op == MD_DIV) || (op == MD_DIVU);
  assign md_start  = start && (op == MD_MULT || op == MD_MULTU || div_op);
  assign mag_a     = (signed_op && ex_op_A[XLEN-1]) ? -ex_op_A : ex_op_A;
  assign mag_b     = (signed_op && ex_op_B[XLEN-1]) ? -ex_op_B : ex_op_B;

  md_iter_core #(.XLEN(XLEN), .ITER(ITER)) u_core (
    .clk      (clk),
    .reset    (reset),
    .start_i  (md_start),
    .abort_i  (md_abort),
    .div_i    (is_div_q),
    .opa_i    (mag_a),
    .opb_i    (mag_b),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  always_comb begin
    prod = qneg_q ? -result : result;
    quo  = qneg_q ? -result[XLEN-1:0] : result[XLEN-1:0];
    rem  = rneg_q ? -result[2*XLEN-1:XLEN] : result[2*XLEN-1:XLEN];
  end

  // A zero divisor leaves the quotient unsigned so it reads all-ones, and the
  // remainder path reconstructs the raw dividend from its magnitude.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    issued_d = cu_stall ? (issued_q || start) : 1'b0;
    if (start) begin
      case (op)
        MD_MTHI: hi_d = ex_op_A;
        MD_MTLO: lo_d = ex_op_A;
        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
          is_div_d = div_op;
          qneg_d   = signed_op && (ex_op_A[XLEN-1] ^ ex_op_B[XLEN-1]) &&
                     !(div_op && ex_op_B == '0);
          rneg_d   = signed_op && div_op && ex_op_A[XLEN-1];
        end
        default: ;
      endcase
    end
    if (done) begin
      if (is_div_q) begin
        hi_d = rem;
        lo_d = quo;
      end else begin
        hi_d = prod[2*XLEN-1:XLEN];
        lo_d = prod[XLEN-1:0];
      end
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      issued_q <= 1'b0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      issued_q <= issued_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign md_busy  = busy;
  assign md_stall = busy && valid;
  assign md_hi    = hi_q;
  assign md_lo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv with hand-computed HI/LO results.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk, reset, ex_nop, cu_stall, md_abort;
  logic [2:0]  ex_md_op;
  logic [31:0] ex_op_A, ex_op_B;
  logic        md_busy, md_stall;
  logic [31:0] md_hi, md_lo;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  ex_muldiv #(.XLEN(32), .ITER(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .ex_nop   (ex_nop),
    .ex_md_op (ex_md_op),
    .ex_op_A  (ex_op_A),
    .ex_op_B  (ex_op_B),
    .cu_stall (cu_stall),
    .md_abort (md_abort),
    .md_busy  (md_busy),
    .md_stall (md_stall),
    .md_hi    (md_hi),
    .md_lo    (md_lo)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_md(input string tag, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi_exp,
                        input logic [31:0] lo_exp);
    int unsigned n;
    ex_md_op = op;
    ex_op_A  = a;
    ex_op_B  = b;
    cu_stall = 1'b0;
    tick();
    ex_md_op = MD_NONE;
    n = 0;
    while (md_busy && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd32);
    chk({tag, "_hi"}, 64'(md_hi), 64'(hi_exp));
    chk({tag, "_lo"}, 64'(md_lo), 64'(lo_exp));
  endtask

  initial begin
    int unsigned n, starts, busy_edges;
    logic prev, b1, b2;
    reset = 1'b1; ex_nop = 1'b0; ex_md_op = MD_NONE;
    ex_op_A = '0; ex_op_B = '0; cu_stall = 1'b0; md_abort = 1'b0;
    #12;
    chk("rst_hi", 64'(md_hi), 64'd0);
    chk("rst_lo", 64'(md_lo), 64'd0);
    chk("rst_busy", 64'(md_busy), 64'd0);
    chk("rst_stall", 64'(md_stall), 64'd0);
    tick();
    reset = 1'b0;

    // MULTU with a dependent MFHILO waiting in EX
    ex_md_op = MD_MULTU; ex_op_A = 32'hFFFF_FFFF; ex_op_B = 32'hFFFF_FFFF;
    tick();
    ex_md_op = MD_MFHILO; cu_stall = 1'b1;
    #1;
    chk("multu_stall_on", 64'(md_stall), 64'd1);
    n = md_busy ? 1 : 0;
    for (int i = 0; i < 31; i++) begin
      tick();
      if (md_busy) n++;
    end
    chk("multu_busy_edges", 64'(n), 64'd32);
    tick();
    chk("multu_done_busy", 64'(md_busy), 64'd0);
    chk("multu_stall_off", 64'(md_stall), 64'd0);
    chk("multu_hi", 64'(md_hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(md_lo), 64'h0000_0001);
    tick();
    ex_md_op = MD_NONE; cu_stall = 1'b0;
    tick();

    run_md("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_md("div_7_m2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_md("divu_5_0", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_md("div_m9_0", MD_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
    run_md("mult_m3_5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    // MULT held in EX under a long pipeline stall
    ex_md_op = MD_MULT; ex_op_A = 32'd3; ex_op_B = 32'd4; cu_stall = 1'b1;
    starts = 0; busy_edges = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (md_busy && !prev) starts++;
      if (md_busy) busy_edges++;
      prev = md_busy;
    end
    chk("held_starts", 64'(starts), 64'd1);
    chk("held_busy_edges", 64'(busy_edges), 64'd32);
    chk("held_hi", 64'(md_hi), 64'd0);
    chk("held_lo", 64'(md_lo), 64'd12);
    cu_stall = 1'b0;
    tick();
    chk("held_issued_clr", 64'(dut.issued_q), 64'd0);
    chk("held_no_restart", 64'(md_busy), 64'd0);
    ex_md_op = MD_NONE;
    tick();

    // MTHI / MTLO back-to-back
    ex_md_op = MD_MTHI; ex_op_A = 32'h1234;
    tick();
    b1 = md_busy;
    ex_md_op = MD_MTLO; ex_op_A = 32'h5678;
    tick();
    b2 = md_busy;
    ex_md_op = MD_NONE;
    chk("mt_busy", 64'(b1 | b2), 64'd0);
    chk("mthi", 64'(md_hi), 64'h1234);
    chk("mtlo", 64'(md_lo), 64'h5678);

    // abort mid-multiply, then abort on a would-be start edge
    ex_md_op = MD_MULT; ex_op_A = 32'd7; ex_op_B = 32'd9;
    tick();
    ex_md_op = MD_NONE;
    for (int i = 0; i < 9; i++) tick();
    chk("abort_pre_busy", 64'(md_busy), 64'd1);
    md_abort = 1'b1;
    tick();
    md_abort = 1'b0;
    chk("abort_busy", 64'(md_busy), 64'd0);
    for (int i = 0; i < 30; i++) tick();
    chk("abort_hi", 64'(md_hi), 64'h1234);
    chk("abort_lo", 64'(md_lo), 64'h5678);
    ex_md_op = MD_MULT; md_abort = 1'b1;
    tick();
    chk("abort_start", 64'(md_busy), 64'd0);
    ex_md_op = MD_NONE; md_abort = 1'b0;
    tick();

    // asynchronous reset mid-DIVU
    ex_md_op = MD_DIVU; ex_op_A = 32'd100; ex_op_B = 32'd7;
    tick();
    ex_md_op = MD_NONE;
    for (int i = 0; i < 15; i++) tick();
    chk("rstmid_pre_busy", 64'(md_busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_hi", 64'(md_hi), 64'd0);
    chk("rstmid_lo", 64'(md_lo), 64'd0);
    chk("rstmid_busy", 64'(md_busy), 64'd0);
    tick();
    reset = 1'b0;
    run_md("post_rst_mult", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
